// File: rtl/counter_pkg.sv
// Shared constants for the parametrised up/down counter family.
// No logic, no latency.
// No flow control; constants only.
package counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/counter_next_val.sv
// Next-state arithmetic for the up/down counter: step, wrap or saturate.
// Purely combinational, zero latency.
// No backpressure; evaluates every cycle from current count and controls.
module counter_next_val
  import counter_pkg::*;
#(
  parameter int              WIDTH   = 8,
  parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 1
) (
  input  logic [WIDTH-1:0] count,
  input  logic             dir,
  input  logic             en,
  input  logic             mode,
  output logic [WIDTH-1:0] next_count,
  output logic             wrap_evt,
  output logic             sat_evt
);

  // One extra bit so the increment cannot overflow before the limit compare
  localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MAX_VAL);

  logic [WIDTH:0] sum_up;
  logic [WIDTH:0] sum_dn;

  assign sum_up = {1'b0, count} + 1'b1;
  assign sum_dn = {1'b0, count} - 1'b1;

  // Step within 0..MAX_VAL; at a limit either wrap to the other end or hold
  always_comb begin
    next_count = count;
    wrap_evt   = 1'b0;
    sat_evt    = 1'b0;
    if (en) begin
      if (dir == DIR_UP) begin
        if (sum_up <= MAX_EXT) begin
          next_count = sum_up[WIDTH-1:0];
        end else if (mode == MODE_WRAP) begin
          next_count = '0;
          wrap_evt   = 1'b1;
        end else begin
          sat_evt    = 1'b1;
        end
      end else begin
        // Borrow out of the top bit means count was already 0
        if (!sum_dn[WIDTH]) begin
          next_count = sum_dn[WIDTH-1:0];
        end else if (mode == MODE_WRAP) begin
          next_count = MAX_EXT[WIDTH-1:0];
          wrap_evt   = 1'b1;
        end else begin
          sat_evt    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/counter_updown_param.sv
// Parametrised up/down counter with load, wrap/saturate mode and event flags.
// count/wrapped/at_limit update 1 cycle after en/load sampled; tc is combinational.
// No backpressure; accepts a control command on every rising edge.
module counter_updown_param
  import counter_pkg::*;
#(
  parameter int              WIDTH    = 8,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 1,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrapped,
  output logic             at_limit
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic             MODE  = SATURATE ? MODE_SAT : MODE_WRAP;

  logic [WIDTH-1:0] next_count;
  logic             wrap_evt;
  logic             sat_evt;
  logic [WIDTH-1:0] load_clamped;

  counter_next_val #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_next (
    .count      (count),
    .dir        (dir),
    .en         (en),
    .mode       (MODE),
    .next_count (next_count),
    .wrap_evt   (wrap_evt),
    .sat_evt    (sat_evt)
  );

  // Loaded values above the modulus are clamped so count never leaves 0..MAX_VAL
  assign load_clamped = (64'(load_val) > MAX_VAL) ? MAX_W : load_val;

  // Load beats counting; with en low the next-value block returns a plain hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      wrapped  <= 1'b0;
      at_limit <= 1'b0;
    end else if (load) begin
      count    <= load_clamped;
      wrapped  <= 1'b0;
      at_limit <= 1'b0;
    end else begin
      count    <= next_count;
      wrapped  <= wrap_evt;
      at_limit <= sat_evt;
    end
  end

  // Terminal count looks at the limit in the currently requested direction
  assign tc = (dir == DIR_UP) ? (count == MAX_W) : (count == '0);

endmodule

// File: tb/tb_counter_updown_param.sv
module tb_counter_updown_param;

  typedef struct {
    int         id;
    string      name;
    logic [7:0] cnt;
    logic       wr;
    logic       al;
    logic       tc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       dir;
  logic [7:0] load_val;
  logic       en0, en1, en2;
  logic       ld0, ld1, ld2;

  logic [7:0] c0, c2;
  logic [3:0] c1;
  logic       tc0, tc1, tc2;
  logic       wr0, wr1, wr2;
  logic       al0, al1, al2;

  exp_t sbq[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  // Default 8-bit wrap counter
  counter_updown_param u_dut0 (
    .clk(clk), .reset(reset), .en(en0), .dir(dir), .load(ld0),
    .load_val(load_val), .count(c0), .tc(tc0), .wrapped(wr0), .at_limit(al0)
  );

  // Decade counter
  counter_updown_param #(.WIDTH(4), .MAX_VAL(9)) u_dut1 (
    .clk(clk), .reset(reset), .en(en1), .dir(dir), .load(ld1),
    .load_val(load_val[3:0]), .count(c1), .tc(tc1), .wrapped(wr1), .at_limit(al1)
  );

  // 8-bit saturating counter
  counter_updown_param #(.WIDTH(8), .SATURATE(1'b1)) u_dut2 (
    .clk(clk), .reset(reset), .en(en2), .dir(dir), .load(ld2),
    .load_val(load_val), .count(c2), .tc(tc2), .wrapped(wr2), .at_limit(al2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic idle();
    en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
    ld0 = 1'b0; ld1 = 1'b0; ld2 = 1'b0;
  endtask

  // Drive one instance for one edge and queue the state expected after that edge
  task automatic step(input int id, input logic e, input logic d, input logic l,
                      input logic [7:0] lv, input logic [7:0] ec, input logic ewr,
                      input logic eal, input logic etc, input string nm);
    exp_t x;
    idle();
    case (id)
      0: begin en0 = e; ld0 = l; end
      1: begin en1 = e; ld1 = l; end
      default: begin en2 = e; ld2 = l; end
    endcase
    dir      = d;
    load_val = lv;
    x.id = id; x.name = nm; x.cnt = ec; x.wr = ewr; x.al = eal; x.tc = etc;
    sbq.push_back(x);
    @(negedge clk);
  endtask

  // Monitor: after each edge compare the addressed instance against the queue head
  initial begin
    exp_t x;
    logic [7:0] a_cnt;
    logic a_wr, a_al, a_tc;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        x = sbq.pop_front();
        case (x.id)
          0:       begin a_cnt = c0;         a_wr = wr0; a_al = al0; a_tc = tc0; end
          1:       begin a_cnt = {4'b0, c1}; a_wr = wr1; a_al = al1; a_tc = tc1; end
          default: begin a_cnt = c2;         a_wr = wr2; a_al = al2; a_tc = tc2; end
        endcase
        chk({x.name, ".count"},    32'(a_cnt), 32'(x.cnt));
        chk({x.name, ".wrapped"},  32'(a_wr),  32'(x.wr));
        chk({x.name, ".at_limit"}, 32'(a_al),  32'(x.al));
        chk({x.name, ".tc"},       32'(a_tc),  32'(x.tc));
      end
    end
  end

  initial begin
    idle();
    reset    = 1'b0;
    dir      = 1'b1;
    load_val = 8'h00;
    en0      = 1'b1;

    // Reset holds everything at zero even with en asserted
    #12;
    chk("rst.count",    32'(c0),  32'd0);
    chk("rst.wrapped",  32'(wr0), 32'd0);
    chk("rst.at_limit", 32'(al0), 32'd0);
    chk("rst.dec",      32'(c1),  32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Count up 1..10 after release
    for (int i = 1; i <= 10; i++)
      step(0, 1, 1, 0, 8'h00, 8'(i), 0, 0, 0, "up");

    // Upper wrap in default counter
    step(0, 0, 1, 1, 8'd254, 8'd254, 0, 0, 0, "ld254");
    step(0, 1, 1, 0, 8'd0,   8'd255, 0, 0, 1, "wrap255");
    step(0, 1, 1, 0, 8'd0,   8'd0,   1, 0, 0, "wrap0");
    step(0, 1, 1, 0, 8'd0,   8'd1,   0, 0, 0, "wrap1");

    // Decade counter: down wrap, clamped load, up wrap, tc in down direction
    step(1, 1, 0, 0, 8'd0,  8'd9, 1, 0, 0, "dec_dn9");
    step(1, 1, 0, 0, 8'd0,  8'd8, 0, 0, 0, "dec_dn8");
    step(1, 0, 1, 1, 8'd12, 8'd9, 0, 0, 1, "dec_ld12");
    step(1, 1, 1, 0, 8'd0,  8'd0, 1, 0, 0, "dec_upwrap");
    step(1, 0, 0, 0, 8'd0,  8'd0, 0, 0, 1, "dec_tcdn");

    // Saturating counter at both ends
    step(2, 0, 0, 1, 8'd1,   8'd1,   0, 0, 0, "sat_ld1");
    step(2, 1, 0, 0, 8'd0,   8'd0,   0, 0, 1, "sat_dn0");
    step(2, 1, 0, 0, 8'd0,   8'd0,   0, 1, 1, "sat_dn1");
    step(2, 1, 0, 0, 8'd0,   8'd0,   0, 1, 1, "sat_dn2");
    step(2, 0, 1, 1, 8'd254, 8'd254, 0, 0, 0, "sat_ld254");
    step(2, 1, 1, 0, 8'd0,   8'd255, 0, 0, 1, "sat_up255");
    step(2, 1, 1, 0, 8'd0,   8'd255, 0, 1, 1, "sat_hold");
    step(2, 0, 1, 0, 8'd0,   8'd255, 0, 0, 1, "sat_idle");

    // Load beats enable, then hold, then direction change without skipping
    step(0, 1, 1, 1, 8'h40, 8'h40, 0, 0, 0, "prio_ld");
    step(0, 0, 1, 0, 8'h00, 8'h40, 0, 0, 0, "prio_hold");
    step(0, 1, 1, 0, 8'h00, 8'h41, 0, 0, 0, "dir_up");
    step(0, 1, 0, 0, 8'h00, 8'h40, 0, 0, 0, "dir_dn");

    // Asynchronous reset mid-cycle while counting at 0x80
    step(0, 0, 1, 1, 8'h7F, 8'h7F, 0, 0, 0, "pre_rst_ld");
    step(0, 1, 1, 0, 8'h00, 8'h80, 0, 0, 0, "pre_rst_up");
    idle();
    #2;
    reset = 1'b0;
    #1;
    chk("arst.count",    32'(c0),  32'd0);
    chk("arst.wrapped",  32'(wr0), 32'd0);
    chk("arst.at_limit", 32'(al0), 32'd0);
    chk("arst.sat",      32'(c2),  32'd0);
    @(negedge clk);
    reset = 1'b1;
    step(0, 1, 1, 0, 8'h00, 8'd1, 0, 0, 0, "post_rst1");
    step(0, 1, 1, 0, 8'h00, 8'd2, 0, 0, 0, "post_rst2");
    idle();

    // Bounded drain of the scoreboard
    for (int i = 0; i < 5 && sbq.size() > 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
